// File: rtl/xup_nand_sched_pkg.sv
// Shared types and constants for the vector NAND scheduler.
//   sched_state_t : scheduler FSM state encoding
//   OP_COUNT_W    : width of the optional completed-operation counter
//   id_w()        : index width for N requesters (at least 1 bit)
package xup_nand_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    localparam int OP_COUNT_W = 16;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xup_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr with wrap and picks the first active request.
// Ports:
//   req      : request vector
//   ptr      : highest-priority index for this search (must be < NREQ)
//   grant    : one-hot winner (all zero when no request)
//   grant_id : winner index
//   valid    : at least one request present
module xup_rr_arbiter
    import xup_nand_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [id_w(NREQ)-1:0]    ptr,
    output logic [NREQ-1:0]          grant,
    output logic [id_w(NREQ)-1:0]    grant_id,
    output logic                     valid
);

    localparam int IDW = id_w(NREQ);

    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/xup_nand_vector_sched.sv
// Round-robin scheduler sharing one external SIZE-bit vector NAND unit
// between NREQ requesters. The winner's operands are latched onto
// nand_a/nand_b, held for SETTLE_CYC cycles, then nand_y is registered
// into y_out with a one-cycle done pulse tagged by done_id.
// Optional build macro: XUP_NAND_SCHED_STATS_EN adds the op_count port.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   req              : per-requester request level
//   a_in, b_in       : packed operands, requester i at [i*SIZE +: SIZE]
//   gnt              : one-cycle one-hot grant
//   done, done_id    : result-valid pulse and owning requester
//   y_out            : registered NAND result
//   nand_a, nand_b   : operands driven to the shared NAND unit
//   nand_y           : result from the shared NAND unit
//   op_count         : completed operations (STATS build only)
//
// state | meaning
// IDLE  | waiting for a request; outputs hold last values
// BUSY  | operands on NAND unit, counting down settle cycles
module xup_nand_vector_sched
    import xup_nand_sched_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*SIZE-1:0]     a_in,
    input  logic [NREQ*SIZE-1:0]     b_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     done,
    output logic [id_w(NREQ)-1:0]    done_id,
    output logic [SIZE-1:0]          y_out,
    output logic [SIZE-1:0]          nand_a,
    output logic [SIZE-1:0]          nand_b,
    input  logic [SIZE-1:0]          nand_y
`ifdef XUP_NAND_SCHED_STATS_EN
    ,
    output logic [OP_COUNT_W-1:0]    op_count
`endif
);

    localparam int IDW   = id_w(NREQ);
    localparam int CNT_W = id_w(SETTLE_CYC + 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_id;
    logic             arb_valid;
    logic             start;
    logic             finish;

    xup_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req      (req),
        .ptr      (ptr),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .valid    (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    start     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers. gnt/done are pulses; everything else holds
    // between operations so the last result stays visible in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            y_out   <= '0;
            nand_a  <= '0;
            nand_b  <= '0;
            cnt     <= '0;
            win_id  <= '0;
            ptr     <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            if (start) begin
                gnt    <= arb_grant;
                nand_a <= a_in[int'(arb_id)*SIZE +: SIZE];
                nand_b <= b_in[int'(arb_id)*SIZE +: SIZE];
                cnt    <= CNT_W'(SETTLE_CYC);
                win_id <= arb_id;
            end else if (state == BUSY) begin
                if (finish) begin
                    y_out   <= nand_y;
                    done    <= 1'b1;
                    done_id <= win_id;
                    // Explicit wrap keeps non-power-of-two NREQ in range.
                    ptr     <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef XUP_NAND_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (finish) begin
            op_count <= op_count + OP_COUNT_W'(1);
        end
    end
`endif

endmodule
